// File: rtl/mdu_pkg.sv
// Shared constants for the sequential MIPS multiplier (state encoding, widths)
// plus the operand magnitude helper used by the signed build.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = 32;
  localparam int MDU_CNT_W = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  typedef logic [MDU_CNT_W-1:0] mdu_cnt_t;

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [MDU_WIDTH-1:0] mdu_abs(input logic [MDU_WIDTH-1:0] v,
                                                   input logic                 sgn);
    return (sgn && v[MDU_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/adder_32bit.sv
// Plain 32-bit ripple/inferred adder with carry in and carry out; the
// iteration adder of the sequential multiplier.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out
);

  assign {c_out, s} = {1'b0, a} + {1'b0, b} + {32'b0, c_in};

endmodule

// File: rtl/mdu_mult_seq.sv
// Iterative shift-add 32x32 multiplier feeding HI/LO (33-cycle latency).
// Define MDU_SIGNED_EN to honour is_signed (MULT); otherwise everything is MULTU.
module mdu_mult_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  generate
    if (WIDTH != MDU_WIDTH) begin : g_width_chk
      $error("mdu_mult_seq: only WIDTH=32 is supported by adder_32bit");
    end
  endgenerate

  logic [1:0]           state_q, state_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     m_q, m_d;
  mdu_cnt_t             count_q, count_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     add_s;
  logic                 add_c;
  logic [WIDTH-1:0]     step_s;
  logic                 step_c;

  assign accept = (state_q == ST_IDLE) && start && !flush;

`ifdef MDU_SIGNED_EN
  logic neg_q;
  logic neg_in;

  assign a_mag  = mdu_abs(op_a, is_signed);
  assign b_mag  = mdu_abs(op_b, is_signed);
  assign neg_in = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
  assign result = neg_q ? (~p_q + 64'd1) : p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      neg_q <= 1'b0;
    else if (accept) neg_q <= neg_in;
  end
`else
  logic unused_signed;

  assign a_mag         = op_a;
  assign b_mag         = op_b;
  assign result        = p_q;
  assign unused_signed = is_signed;
`endif

  adder_32bit u_add (
    .a     (p_q[2*WIDTH-1:WIDTH]),
    .b     (m_q),
    .c_in  (1'b0),
    .s     (add_s),
    .c_out (add_c)
  );

  // Multiplier LSB selects add-or-pass; the carry becomes the new MSB on shift.
  assign step_s = p_q[0] ? add_s : p_q[2*WIDTH-1:WIDTH];
  assign step_c = p_q[0] ? add_c : 1'b0;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          p_d     = {{WIDTH{1'b0}}, b_mag};
          m_d     = a_mag;
          count_d = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          p_d     = {step_c, step_s, p_q[WIDTH-1:1]};
          count_d = count_q + mdu_cnt_t'(1);
          if (count_q == mdu_cnt_t'(MDU_ITER-1)) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        if (!flush) begin
          {hi_d, lo_d} = result;
          done_d       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_mult_seq.sv
// Self-checking bench for mdu_mult_seq: directed cases plus random traffic
// compared every cycle against a countdown/arithmetic reference model.
module tb_mdu_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, is_signed, flush;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mdu_mult_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Reference: an accepted op occupies the unit for 33 edges, then publishes.
  int          m_rem;
  logic        m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem != 0) begin
        if (flush) m_rem <= 0;
        else begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            {m_hi, m_lo} <= m_pend;
            m_done       <= 1'b1;
          end
        end
      end else if (start && !flush) begin
`ifdef MDU_SIGNED_EN
        m_pend <= ref_mul(op_a, op_b, is_signed);
`else
        m_pend <= ref_mul(op_a, op_b, 1'b0);
`endif
        m_rem  <= 33;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", {63'b0, busy}, {63'b0, (m_rem != 0)});
    chk("cyc_done", {63'b0, done}, {63'b0, m_done});
    chk("cyc_hi", {32'b0, hi}, {32'b0, m_hi});
    chk("cyc_lo", {32'b0, lo}, {32'b0, m_lo});
  end

  // Called just after a posedge with the unit idle; returns just after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    int n;
    n = 0;
    nbusy = busy ? 1 : 0;
    lat = -1;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (!done && busy) nbusy++;
    end
    if (!done) chk("timeout_done", 64'd0, 64'd1);
    else lat = cyc - acc_cyc;
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eh, input logic [31:0] el);
    int lat, nb;
    issue(a, b, s);
    wait_done(lat, nb);
    chk({nm, "_lat"}, 64'(lat), 64'd33);
    chk({nm, "_busycyc"}, 64'(nb), 64'd33);
    chk({nm, "_hi"}, {32'b0, hi}, {32'b0, eh});
    chk({nm, "_lo"}, {32'b0, lo}, {32'b0, el});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, nb, ndone;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
    op_a = '0; op_b = '0;
    #12;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("unsigned", 32'h0000_FFFF, 32'h0001_0001, 1'b0, 32'h0, 32'hFFFF_FFFF);
    run_op("fullrange", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h1);
`ifdef MDU_SIGNED_EN
    run_op("neg3x7", 32'hFFFF_FFFD, 32'h7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
`else
    run_op("neg3x7", 32'hFFFF_FFFD, 32'h7, 1'b1, 32'h6, 32'hFFFF_FFEB);
`endif
    run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0);
    run_op("zero", 32'h0, 32'h1234_5678, 1'b1, 32'h0, 32'h0);

    // Flush mid-calculation keeps the previous result.
    run_op("preload", 32'h2222_2222, 32'h8000_0001, 1'b0, 32'h1111_1111, 32'h2222_2222);
    issue(32'd5, 32'd6, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_done", {63'b0, done}, 64'd0);
    chk("flush_hi", {32'b0, hi}, 64'h1111_1111);
    chk("flush_lo", {32'b0, lo}, 64'h2222_2222);
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
    chk("flush_nodone", 64'(ndone), 64'd0);

    // Back-to-back: start in the done cycle is accepted, mid-op start is ignored.
    issue(32'd7, 32'd9, 1'b0);
    wait_done(lat, nb);
    chk("b2b_first_lo", {32'b0, lo}, 64'd63);
    issue(32'd2, 32'd3, 1'b0);
    chk("b2b_accept_busy", {63'b0, busy}, 64'd1);
    repeat (10) @(posedge clk);
    #1 op_a = 32'd100; op_b = 32'd100; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat, nb);
    chk("b2b_lat", 64'(lat), 64'd33);
    chk("b2b_hi", {32'b0, hi}, 64'd0);
    chk("b2b_lo", {32'b0, lo}, 64'd6);
    @(posedge clk); #1;
    chk("b2b_idle_after", {63'b0, busy}, 64'd0);

    // flush and start together in IDLE: start dropped.
    op_a = 32'd9; op_b = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    chk("flushstart_busy", {63'b0, busy}, 64'd0);

    // Asynchronous reset between edges mid-CALC.
    issue(32'h1234, 32'h5678, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_done", {63'b0, done}, 64'd0);
    chk("arst_hi", {32'b0, hi}, 64'd0);
    chk("arst_lo", {32'b0, lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
    chk("arst_nodone", 64'(ndone), 64'd0);

    // Random traffic, checked every cycle by the compare process.
    repeat (3000) begin
      start     = ($urandom % 4) == 0;
      flush     = ($urandom % 50) == 0;
      is_signed = $urandom % 2;
      op_a      = pick();
      op_b      = pick();
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_mult_seq.md
Name: mdu_mult_seq

Overview:
- Iterative shift-add 32x32 multiplier for the MIPS MULT/MULTU path; writes the 64-bit product into the HI/LO registers.
- Sits downstream of the register-file read ports and upstream of the HI/LO consumers (MFHI/MFLO).
- Each iteration adds the multiplicand into the upper partial product through one adder_32bit instance (carry-in 0; c_out is used as the shift-in bit).
- The execute stage stalls on busy.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported, since adder_32bit is fixed-width. Elaboration fails for any other value.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- is_signed  input  1  1 = MULT (signed), 0 = MULTU
- op_a  input  32  multiplicand (rs)
- op_b  input  32  multiplier (rt)
- flush  input  1  abort an in-flight operation (pipeline flush or exception)
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when hi/lo have just been updated
- hi  output  32  product[63:32]
- lo  output  32  product[31:0]

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, busy=0, done=0, hi=0, lo=0, all internal registers 0. Reset asserted mid-operation aborts immediately.
- States: IDLE, CALC, WRITE.
- IDLE:
  - On start=1 at edge E0: latch operands as magnitudes (absolute values if signed), latch neg = sign(a) XOR sign(b).
  - Load P = {32'b0, |b|} and M = |a|, set count=0, go to CALC, busy=1 from E0.
- CALC, one iteration per edge:
  - If P[0] is set, {c, s} = P[63:32] + M via adder_32bit; otherwise {c, s} = {0, P[63:32]}.
  - Update P = {c, s, P[31:1]}, then count++.
  - After 32 iterations (edges E1..E32) go to WRITE.
- WRITE, at edge E33:
  - {hi, lo} = neg ? (~P + 1) : P, as a 64-bit two's complement.
  - done=1 for the cycle after E33; busy=0 from E33; return to IDLE.
  - Latency: start-accept edge to done = 33 cycles.
- hi/lo hold their value until the next WRITE. They are never changed by flush or by IDLE.
- start while busy=1 is ignored; no queuing.
- start in the same cycle that done=1 is accepted, since the state is IDLE.
- flush=1 in CALC or WRITE: go to IDLE at the next edge, busy=0, done=0, hi/lo unchanged.
- flush and start both high in IDLE: flush wins, start is dropped.
- Negation boundary: 0x80000000 * 0x80000000 signed gives magnitude 2^62, so hi=0x40000000, lo=0. No overflow is possible in 64 bits.
- Zero operand: still takes the full 33 cycles; result is 0. No early exit.

Optional Feature:
- Macro MDU_SIGNED_EN.
- Defined: is_signed is honoured; absolute-value logic on the operands and the final negation are present.
- Undefined: is_signed is ignored, every operation is unsigned (MULTU semantics), and the abs/negation logic is not synthesised. Port list and latency are identical in both builds.

Decomposition:
- Package mdu_pkg holds:
  - state encoding constants: IDLE=2'd0, CALC=2'd1, WRITE=2'd2
  - MDU_WIDTH=32
  - MDU_ITER=32
  - count width 6
- Sub-module: one instance of the existing adder_32bit as the iteration adder.
- The FSM, shift register and sign logic live in mdu_mult_seq. No further sub-modules.

Test Plan:
- Unsigned: start with op_a=0x0000FFFF, op_b=0x00010001, is_signed=0. Expect done exactly 33 cycles after the accept edge, hi=0x00000000, lo=0xFFFFFFFF, busy high for 33 cycles.
- Full-range unsigned: op_a=op_b=0xFFFFFFFF. Expect hi=0xFFFFFFFE, lo=0x00000001. This exercises c_out=1 on the adder path.
- Signed (MDU_SIGNED_EN): op_a=0xFFFFFFFD (-3), op_b=0x00000007. Expect hi=0xFFFFFFFF, lo=0xFFFFFFEB. In the build without the macro, the same stimulus must give hi=0x00000006, lo=0xFFFFFFEB.
- Flush: start 5*6 with the previous result 0x11111111/0x22222222 held in hi/lo. Assert flush at cycle 10. Expect busy=0 next cycle, no done pulse, hi/lo still 0x11111111/0x22222222.
- Back-to-back: re-assert start in the done cycle with 2*3, and pulse start again mid-op. Expect the second op accepted in the done cycle, the mid-op start ignored, and lo=6 after a further 33 cycles.
- Reset: assert rst_n=0 asynchronously mid-CALC (between edges). Expect busy=0, done=0, hi=lo=0 immediately, and no done after rst_n is released.
